// File: rtl/demux_1_bit_buffered.sv
// 1-to-2 buffered demultiplexer: each input word is steered by C into one of
// two independent per-channel FIFOs, each drained through its own valid/ready port.

module demux_1_bit_buffered_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       ready,
    output logic [WIDTH-1:0]           head,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] last_head;
    logic             pop;

    assign valid = (count != '0);
    assign full  = (count == DEPTH_C);
    assign pop   = valid && ready;

    // When empty the port keeps showing the most recent head word.
    assign head = valid ? mem[rd_ptr] : last_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            last_head <= '0;
        end else begin
            if (valid) begin
                last_head <= mem[rd_ptr];
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Occupancy alone decides full/empty; pointers just wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module demux_1_bit_buffered #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [WIDTH-1:0]       D,
    input  logic                   C,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    output logic [WIDTH-1:0]       A,
    output logic                   A_VALID,
    input  logic                   A_READY,
    output logic [WIDTH-1:0]       B,
    output logic                   B_VALID,
    input  logic                   B_READY,
    output logic [$clog2(DEPTH):0] A_COUNT,
    output logic [$clog2(DEPTH):0] B_COUNT
);
    // Handshake: a word moves on any rising edge where its valid and ready are
    // both high. IN_READY depends only on C and the registered counts, never
    // on A_READY/B_READY, so a full FIFO refuses a push even while popping.
    logic a_full;
    logic b_full;
    logic push_a;
    logic push_b;

    assign IN_READY = RST_N && (C ? !b_full : !a_full);
    assign push_a   = IN_VALID && IN_READY && !C;
    assign push_b   = IN_VALID && IN_READY && C;

    demux_1_bit_buffered_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk     (CLK),
        .rst_n   (RST_N),
        .push    (push_a),
        .wr_data (D),
        .ready   (A_READY),
        .head    (A),
        .valid   (A_VALID),
        .full    (a_full),
        .count   (A_COUNT)
    );

    demux_1_bit_buffered_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk     (CLK),
        .rst_n   (RST_N),
        .push    (push_b),
        .wr_data (D),
        .ready   (B_READY),
        .head    (B),
        .valid   (B_VALID),
        .full    (b_full),
        .count   (B_COUNT)
    );
endmodule

// File: tb/tb_demux_1_bit_buffered.sv
// Bench for demux_1_bit_buffered: per-channel expected queues mirror the
// FIFOs and are compared against the ports on every falling edge.

module tb_demux_1_bit_buffered;
    localparam int WIDTH = 16;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             CLK;
    logic             RST_N;
    logic [WIDTH-1:0] D;
    logic             C;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic             A_VALID;
    logic             A_READY;
    logic [WIDTH-1:0] B;
    logic             B_VALID;
    logic             B_READY;
    logic [CW-1:0]    A_COUNT;
    logic [CW-1:0]    B_COUNT;

    demux_1_bit_buffered #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .D        (D),
        .C        (C),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .A        (A),
        .A_VALID  (A_VALID),
        .A_READY  (A_READY),
        .B        (B),
        .B_VALID  (B_VALID),
        .B_READY  (B_READY),
        .A_COUNT  (A_COUNT),
        .B_COUNT  (B_COUNT)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_a_q[$];
    logic [WIDTH-1:0] exp_b_q[$];
    logic [WIDTH-1:0] last_a = '0;
    logic [WIDTH-1:0] last_b = '0;
    logic             fire   = 1'b0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: compare ports with the model, then apply the transfers the
    // coming rising edge will perform.
    always @(negedge CLK) begin
        logic ready_exp;
        logic a_pop;
        logic b_pop;
        if (!RST_N) begin
            check_value("rst_in_ready", 32'(IN_READY), 32'd0);
            check_value("rst_a_count", 32'(A_COUNT), 32'd0);
            check_value("rst_b_count", 32'(B_COUNT), 32'd0);
            check_value("rst_a_valid", 32'(A_VALID), 32'd0);
            check_value("rst_b_valid", 32'(B_VALID), 32'd0);
            check_value("rst_a_data", 32'(A), 32'd0);
            check_value("rst_b_data", 32'(B), 32'd0);
            exp_a_q.delete();
            exp_b_q.delete();
            last_a = '0;
            last_b = '0;
            fire   = 1'b0;
        end else begin
            check_value("a_count", 32'(A_COUNT), 32'(exp_a_q.size()));
            check_value("b_count", 32'(B_COUNT), 32'(exp_b_q.size()));
            check_value("a_valid", 32'(A_VALID), 32'(exp_a_q.size() != 0));
            check_value("b_valid", 32'(B_VALID), 32'(exp_b_q.size() != 0));
            if (exp_a_q.size() != 0) last_a = exp_a_q[0];
            if (exp_b_q.size() != 0) last_b = exp_b_q[0];
            check_value("a_data", 32'(A), 32'(last_a));
            check_value("b_data", 32'(B), 32'(last_b));
            ready_exp = C ? (exp_b_q.size() != DEPTH) : (exp_a_q.size() != DEPTH);
            check_value("in_ready", 32'(IN_READY), 32'(ready_exp));
            a_pop = A_READY && (exp_a_q.size() != 0);
            b_pop = B_READY && (exp_b_q.size() != 0);
            if (a_pop) void'(exp_a_q.pop_front());
            if (b_pop) void'(exp_b_q.pop_front());
            fire = IN_VALID && ready_exp;
            if (fire) begin
                if (C) exp_b_q.push_back(D);
                else   exp_a_q.push_back(D);
            end
        end
    end

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic drive(input logic v, input logic c, input logic [WIDTH-1:0] d,
                         input logic ar, input logic br, output logic accepted);
        IN_VALID = v;
        C        = c;
        D        = d;
        A_READY  = ar;
        B_READY  = br;
        @(posedge CLK);
        #1;
        accepted = fire;
    endtask

    task automatic idle(input int n, input logic ar, input logic br);
        logic acc;
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, ar, br, acc);
    endtask

    initial begin
        logic acc;
        int   sent;
        int   cyc;
        RST_N = 1'b0; D = '0; C = 1'b0; IN_VALID = 1'b0; A_READY = 1'b0; B_READY = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        idle(2, 1'b1, 1'b1);

        // Basic routing
        drive(1'b1, 1'b0, 16'h1234, 1'b1, 1'b1, acc);
        check_value("route_a_acc", 32'(acc), 32'd1);
        drive(1'b1, 1'b1, 16'hABCD, 1'b1, 1'b1, acc);
        check_value("route_b_acc", 32'(acc), 32'd1);
        idle(3, 1'b1, 1'b1);

        // Fill A, then a push in the same cycle as the first pop is refused
        drive(1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, acc);
        drive(1'b1, 1'b0, 16'h0002, 1'b0, 1'b0, acc);
        drive(1'b1, 1'b0, 16'h0003, 1'b0, 1'b0, acc);
        check_value("full_refuse", 32'(acc), 32'd0);
        drive(1'b1, 1'b0, 16'h0003, 1'b1, 1'b0, acc);
        check_value("no_bypass", 32'(acc), 32'd0);
        drive(1'b1, 1'b0, 16'h0003, 1'b0, 1'b0, acc);
        check_value("push_after_pop", 32'(acc), 32'd1);

        // A full and stalled, B keeps flowing
        drive(1'b1, 1'b1, 16'h00B0, 1'b0, 1'b0, acc);
        check_value("cross_b0", 32'(acc), 32'd1);
        drive(1'b1, 1'b1, 16'h00B1, 1'b0, 1'b0, acc);
        check_value("cross_b1", 32'(acc), 32'd1);
        idle(3, 1'b0, 1'b1);
        idle(3, 1'b1, 1'b1);

        // Wrap-around on B with B_READY toggling
        sent = 0;
        cyc  = 0;
        while (sent < 10 && cyc < 100) begin
            drive(1'b1, 1'b1, WIDTH'(sent), 1'b1, cyc[0], acc);
            if (acc) sent++;
            cyc++;
        end
        check_value("wrap_sent", 32'(sent), 32'd10);
        idle(4, 1'b1, 1'b1);

        // Simultaneous push/pop at count 1
        drive(1'b1, 1'b0, 16'h00AA, 1'b0, 1'b0, acc);
        drive(1'b1, 1'b0, 16'h00BB, 1'b1, 1'b0, acc);
        check_value("pushpop_acc", 32'(acc), 32'd1);
        idle(2, 1'b0, 1'b0);
        idle(2, 1'b1, 1'b1);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), WIDTH'($urandom_range(0, 65535)),
                  $urandom_range(0, 1), $urandom_range(0, 1), acc);
        end
        idle(4, 1'b1, 1'b1);

        // Asynchronous reset with A holding two words
        drive(1'b1, 1'b0, 16'h0C01, 1'b0, 1'b0, acc);
        drive(1'b1, 1'b0, 16'h0C02, 1'b0, 1'b0, acc);
        drive(1'b1, 1'b1, 16'h0C03, 1'b0, 1'b0, acc);
        #1;
        RST_N = 1'b0;
        #1;
        check_value("async_a_valid", 32'(A_VALID), 32'd0);
        check_value("async_b_valid", 32'(B_VALID), 32'd0);
        check_value("async_a_count", 32'(A_COUNT), 32'd0);
        check_value("async_b_count", 32'(B_COUNT), 32'd0);
        check_value("async_a_data", 32'(A), 32'd0);
        check_value("async_b_data", 32'(B), 32'd0);
        check_value("async_in_ready", 32'(IN_READY), 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        drive(1'b1, 1'b0, 16'h5A5A, 1'b1, 1'b1, acc);
        check_value("post_rst_acc", 32'(acc), 32'd1);
        idle(3, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
